// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, buffer entry type and FSM states for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;
  typedef enum logic {RUN, TRAP_HOLD} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: fetch buffer with push/pop/flush; a push alongside a flush lands as the only entry
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);
  localparam int AW = $clog2(DEPTH);
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    wr_d  = flush ? AW'(push) : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? (AW+1)'(push) : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) mem_d[flush ? '0 : wr_q] = push_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing into a fetch buffer; FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a trap entry
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_exc
);
  logic [31:0] pc_q, pc_d, tgt;
  state_t      state_q, state_d;
  logic        fault, push, pop, full, empty;
  entry_t      push_data, head;
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt   = redirect_pc;
    fault = redirect_valid && |redirect_pc[1:0];
`else
    tgt   = redirect_pc & ~32'h3;
    fault = 1'b0;
`endif
    pop       = !empty && out_ready;
    push      = redirect_valid ? fault : state_q == RUN && (!full || pop);
    push_data = redirect_valid ? entry_t'{tgt, NOP_INSTR, 1'b1} : entry_t'{pc_q, imem_instr, 1'b0};
    pc_d      = redirect_valid ? tgt : push ? pc_q + 32'd4 : pc_q;
    state_d   = redirect_valid ? (fault ? TRAP_HOLD : RUN) : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );
  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_exc   = head.exc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stream checked against an expected-PC model
module tb_fetch_stage;
  logic        clk = 0, rst_n = 0;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready, out_exc;
  logic [31:0] w_addr, w_instr, w_rpc, w_instr_o, w_pc;
  logic        w_rv, w_valid, w_ready, w_exc;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign imem_instr = imem_addr;
  assign w_instr    = w_addr;
  fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_instr(w_instr),
    .redirect_valid(w_rv), .redirect_pc(w_rpc), .out_valid(w_valid),
    .out_ready(w_ready), .out_instr(w_instr_o), .out_pc(w_pc), .out_exc(w_exc));
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    rst_n = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    w_rv = 0; w_rpc = 0; w_ready = 1;
    #7;
    @(negedge clk);
    rst_n = 1;
  endtask
  task test_reset;
    rst_n = 0; redirect_valid = 0; out_ready = 1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", imem_addr); end
    n_cmp++; if (out_exc !== 1'b0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", out_exc); end
  endtask
  task test_stream;
    do_reset;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'(4*i)) begin
        n_bad++; $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want pc=%h", i, out_valid, out_pc, out_instr, 4*i);
      end
    end
  endtask
  task test_stall;
    do_reset;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL stall_hold_%0d: got v=%b pc=%h want pc=0", i, out_valid, out_pc); end
    end
    n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL stall_addr: got %h want 8", imem_addr); end
    out_ready = 1;
    for (int i = 1; i < 6; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i)) begin n_bad++; $display("FAIL stall_drain_%0d: got v=%b pc=%h want %h", i, out_valid, out_pc, 4*i); end
    end
  endtask
  task test_redirect;
    do_reset;
    out_ready = 0;
    tick; tick;
    redirect_valid = 1; redirect_pc = 32'h100; out_ready = 1;
    tick;
    redirect_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_gap: got v=%b pc=%h want v=0", out_valid, out_pc); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL redir_seq_%0d: got v=%b pc=%h want %h", i, out_valid, out_pc, 32'h100 + 32'(4*i)); end
    end
  endtask
  task test_wrap;
    logic [31:0] exp [3];
    exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (w_valid !== 1'b1 || w_pc !== exp[i] || w_instr_o !== exp[i]) begin n_bad++; $display("FAIL wrap_%0d: got v=%b pc=%h want %h", i, w_valid, w_pc, exp[i]); end
    end
  endtask
  task test_misalign;
    do_reset;
    out_ready = 1;
    tick; tick;
    redirect_valid = 1; redirect_pc = 32'h102;
    tick;
    redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_instr !== 32'h13 || out_exc !== 1'b1) begin
      n_bad++; $display("FAIL trap_entry: got v=%b pc=%h instr=%h exc=%b want 102/13/1", out_valid, out_pc, out_instr, out_exc);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL trap_hold_%0d: got v=%b pc=%h want v=0", i, out_valid, out_pc); end
    end
    redirect_valid = 1; redirect_pc = 32'h200;
    tick;
    redirect_valid = 0;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_exc !== 1'b0) begin n_bad++; $display("FAIL trap_resume: got v=%b pc=%h exc=%b want 200/0", out_valid, out_pc, out_exc); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL align_gap: got v=%b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_exc !== 1'b0) begin n_bad++; $display("FAIL align_force: got v=%b pc=%h exc=%b want 100/0", out_valid, out_pc, out_exc); end
`endif
  endtask
  task test_reset_mid;
    do_reset;
    out_ready = 0;
    tick; tick; tick; tick;
    #2 rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL midreset: got v=%b addr=%h want 0/0", out_valid, imem_addr); end
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL midreset_restart: got v=%b pc=%h want 0", out_valid, out_pc); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_bad++; $display("FAIL midreset_next: got v=%b pc=%h want 4", out_valid, out_pc); end
  endtask
  task test_random;
    logic [31:0] exp_pc, prev_pc, tmp;
    logic        prev_hold, chk_empty, r, redir;
    int          idle;
    do_reset;
    exp_pc = 0; prev_pc = 0; prev_hold = 0; chk_empty = 0; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if (chk_empty) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush_%0d: got v=%b pc=%h want v=0", i, out_valid, out_pc); end
      end
      if (prev_hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== prev_pc) begin n_bad++; $display("FAIL rnd_stable_%0d: got v=%b pc=%h want %h", i, out_valid, out_pc, prev_pc); end
      end
      idle = out_valid ? 0 : idle + 1;
      n_cmp++; if (idle > 3) begin n_bad++; $display("FAIL rnd_starve_%0d: got %0d idle cycles want <=3", i, idle); end
      r = ($urandom % 4) != 0;
      redir = ($urandom % 25) == 0;
      tmp = $urandom & ~32'h3;
      if (out_valid && r && !redir) begin
        n_cmp++; if (out_pc !== exp_pc || out_instr !== exp_pc || out_exc !== 1'b0) begin
          n_bad++; $display("FAIL rnd_accept_%0d: got pc=%h instr=%h exc=%b want %h", i, out_pc, out_instr, out_exc, exp_pc);
        end
        exp_pc = exp_pc + 4;
      end
      if (redir) exp_pc = tmp;
      prev_hold = out_valid && !r && !redir;
      prev_pc = out_pc;
      chk_empty = redir;
      out_ready = r; redirect_valid = redir; redirect_pc = tmp;
      tick;
    end
    redirect_valid = 0;
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_wrap;
    test_misalign;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the fetch buffer entry count; legal values are 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: current PC, driven to the combinational instruction memory.
REQ-006 SHALL have port imem_instr, input, 32 bits: instruction returned for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer head is valid toward decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port out_instr, output, 32 bits: head instruction.
REQ-012 SHALL have port out_pc, output, 32 bits: head PC.
REQ-013 SHALL have port out_exc, output, 1 bit: head carries an instruction-address-misaligned fault; tied 0 when FETCH_MISALIGN_TRAP_EN is undefined.

Function
REQ-014 SHALL drive imem_addr = pc register.
REQ-015 SHALL push {pc, imem_instr, exc=0} and set pc <= pc+4 on a cycle when fetch is enabled, no redirect is asserted, and the buffer has space or is popped the same cycle.
REQ-016 SHALL pop the head on out_valid && out_ready.
REQ-017 SHALL drive out_valid = buffer not empty, out_* from the head entry, with zero added latency from buffer to port.
REQ-018 SHALL hold pc and push nothing when the buffer is full and not popped.
REQ-019 SHALL allow simultaneous push and pop on a full buffer; count stays at BUF_DEPTH.
REQ-020 SHALL, on redirect_valid, flush all entries (the pop that cycle is discarded), set pc <= redirect_pc, and push nothing; redirect wins over push and pop.
REQ-021 SHALL give one-cycle redirect-to-first-valid latency: out_valid=0 in the cycle after redirect, and the target entry is valid two cycles after redirect.
REQ-022 SHALL compute pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-023 SHALL implement an FSM with states RUN and TRAP_HOLD; fetch is enabled only in RUN.
REQ-024 SHALL keep out_valid stable and out_* unchanged while out_valid && !out_ready.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set pc = RESET_PC, empty the buffer, set FSM = RUN, out_valid = 0, out_exc = 0.
REQ-026 SHALL resume fetching at RESET_PC on the first rising edge after rst_n deasserts; reset mid-stream drops all buffered entries.

Configuration
REQ-027 SHALL, with FETCH_MISALIGN_TRAP_EN defined, treat a redirect with redirect_pc[1:0] != 0 as a fault: push one entry {redirect_pc, 32'h0000_0013, exc=1}, enter TRAP_HOLD, and stop fetching until the next redirect, which returns the FSM to RUN.
REQ-028 SHALL, with FETCH_MISALIGN_TRAP_EN undefined, force redirect_pc[1:0] to 0 and never enter TRAP_HOLD.

Structure
REQ-029 SHALL place the constant NOP_INSTR = 32'h0000_0013, the entry typedef {pc, instr, exc}, and the FSM state enum in package fetch_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo (parameter DEPTH; push/pop/flush, full/empty); all PC and FSM logic stays in fetch_stage.

Verification
REQ-031 SHALL cover reset release with out_ready=1 and memory word = address: out_pc/out_instr = 0x0, 0x4, 0x8 on consecutive cycles from cycle 1.
REQ-032 SHALL cover out_ready=0 for 5 cycles: exactly BUF_DEPTH entries are buffered and imem_addr holds at 0x8; on release, entries drain in order with no loss or duplication.
REQ-033 SHALL cover redirect to 0x100 with 2 entries buffered: next cycle out_valid=0; following cycle out_pc=0x100; stale entries are never seen.
REQ-034 SHALL cover RESET_PC = 0xFFFF_FFF8: out_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 SHALL cover redirect to 0x102 with the macro defined: one entry {0x102, 0x13, exc=1}, no further valids until redirect to 0x200 resumes fetch; with the macro undefined, the first entry is out_pc=0x100, exc=0.
REQ-036 SHALL cover rst_n asserted mid-stall with a full buffer: out_valid drops immediately, and fetch restarts at RESET_PC.
